// File: rtl/windowed_reduction_pipe_pkg.sv
// wred_pkg: elaboration-time helpers for windowed_reduction_pipe.
//   wred_num_stages : number of window stages (intermediate + final)
//   wred_stage_w    : width of the value entering stage i (i = 0 is the input)
//   wred_is_reg     : whether a pipeline register follows stage i (1-based)
//   wred_regs_upto  : number of registers placed after stages 1..i
//   wred_tbl        : (k * 2^q_w) mod q
package wred_pkg;

  function automatic int wred_num_stages(int in_w, int q_w, int win);
    int w;
    int n;
    w = in_w;
    n = 0;
    while (w - win >= q_w) begin
      w = w - win + 1;
      n++;
    end
    return n + 1;
  endfunction

  function automatic int wred_stage_w(int i, int in_w, int q_w, int win);
    int w;
    w = in_w;
    for (int j = 0; j < i; j++) begin
      if (w - win >= q_w) w = w - win + 1;
      else                w = q_w + 1;
    end
    return w;
  endfunction

  // The final window stage feeds the correction register directly.
  function automatic bit wred_is_reg(int i, int n, int pe);
    return (i >= 1) && (i % pe == 0) && (i != n);
  endfunction

  function automatic int wred_regs_upto(int i, int n, int pe);
    int c;
    c = 0;
    for (int j = 1; j <= i; j++) if (wred_is_reg(j, n, pe)) c++;
    return c;
  endfunction

  // Repeated doubling keeps every intermediate below 2q, so no 64-bit overflow.
  function automatic longint unsigned wred_tbl(longint unsigned k, longint unsigned q, int q_w);
    longint unsigned r;
    r = k % q;
    for (int i = 0; i < q_w; i++) begin
      r = r << 1;
      if (r >= q) r = r - q;
    end
    return r;
  endfunction

endpackage

// File: rtl/windowed_reduction_pipe_if.sv
// Stream interface of windowed_reduction_pipe.
//   in_valid/in_ready/in_data    : words to reduce (IN_W bits)
//   out_valid/out_ready/out_data : reduced results (Q_W bits)
//   in_tag/out_tag               : sideband tag, present only with WRED_TAG_EN
// modport master: producer/consumer side; modport slave: the reducer.
interface windowed_reduction_pipe_if #(
  parameter int IN_W = 60,
  parameter int Q_W  = 30
`ifdef WRED_TAG_EN
  , parameter int TAG_W = 8
`endif
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [Q_W-1:0]  out_data;
`ifdef WRED_TAG_EN
  logic [TAG_W-1:0] in_tag;
  logic [TAG_W-1:0] out_tag;
`endif

  modport master (
    output in_valid, output in_data, input in_ready,
    input out_valid, input out_data, output out_ready
`ifdef WRED_TAG_EN
    , output in_tag, input out_tag
`endif
  );

  modport slave (
    input in_valid, input in_data, output in_ready,
    output out_valid, output out_data, input out_ready
`ifdef WRED_TAG_EN
    , input in_tag, output out_tag
`endif
  );
endinterface

// File: rtl/windowed_reduction_pipe_lut.sv
// windowed_reduction_lut: combinational ROM, t_o = (idx_i * 2^Q_W) mod Q.
//   idx_i : window index (WIN bits)
//   t_o   : table entry (Q_W bits)
module windowed_reduction_lut
  import wred_pkg::*;
#(
  parameter longint unsigned Q   = 64'd1063321601,
  parameter int              Q_W = 30,
  parameter int              WIN = 6
) (
  input  logic [WIN-1:0] idx_i,
  output logic [Q_W-1:0] t_o
);
  logic [Q_W-1:0] rom [2**WIN];

  for (genvar k = 0; k < 2**WIN; k++) begin : g_rom
    assign rom[k] = Q_W'(wred_tbl(64'(k), Q, Q_W));
  end

  assign t_o = rom[idx_i];
endmodule

// File: rtl/windowed_reduction_pipe.sv
// windowed_reduction_pipe: elastic in_data mod Q reducer built from table-lookup
// window stages and a registered final 2Q/Q conditional subtraction.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : windowed_reduction_pipe_if.slave (in_* / out_* ready-valid streams)
// Optional macro WRED_TAG_EN adds parameter TAG_W and in_tag/out_tag, carried in
// lockstep with the data through every pipeline register.
module windowed_reduction_pipe
  import wred_pkg::*;
#(
  parameter int              IN_W       = 60,
  parameter int              Q_W        = 30,
  parameter longint unsigned Q          = 64'd1063321601,
  parameter int              WIN        = 6,
  parameter int              PIPE_EVERY = 2
`ifdef WRED_TAG_EN
  , parameter int            TAG_W      = 8
`endif
) (
  input logic clk,
  input logic rst_n,
  windowed_reduction_pipe_if.slave bus
);
  localparam int N  = wred_num_stages(IN_W, Q_W, WIN);
  localparam int NR = wred_regs_upto(N, N, PIPE_EVERY);  // index of the output register
  localparam int CW = Q_W + 3;

  if (!((Q > (64'd1 << (Q_W - 1))) && (Q < (64'd1 << Q_W)) && (WIN >= 2))) begin : g_bad_cfg
    $error("windowed_reduction_pipe: need 2^(Q_W-1) < Q < 2^Q_W and WIN >= 2");
  end

  // Handshake: a register may load when it is empty or the one after it loads.
  logic [NR:0] v_q, v_d, ld, up, en;

  always_comb begin
    logic stall;
    stall = !bus.out_ready;
    for (int s = NR; s >= 0; s--) begin
      stall = stall && v_q[s];
      ld[s] = !stall;
    end
    up[0] = bus.in_valid;
    for (int s = 1; s <= NR; s++) up[s] = v_q[s-1];
    en  = ld & up;            // data only moves when a real word arrives
    v_d = en | (~ld & v_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v_q[NR];

  for (genvar g = 0; g < N; g++) begin : g_st
    localparam int WI = wred_stage_w(g, IN_W, Q_W, WIN);
    localparam int WO = wred_stage_w(g + 1, IN_W, Q_W, WIN);
    localparam int P  = (g == N - 1) ? Q_W : WI - WIN;

    logic [WI-1:0]  x;
    logic [WIN-1:0] idx;
    logic [Q_W-1:0] t;
    logic [WO-1:0]  x_d;
    logic [WO-1:0]  y;

    if (g == 0) begin : g_src
      assign x = bus.in_data;
    end else begin : g_src
      assign x = g_st[g-1].y;
    end

    // Final stage index is narrower than WIN and is zero-extended.
    assign idx = WIN'(x[WI-1:P]);

    windowed_reduction_lut #(.Q(Q), .Q_W(Q_W), .WIN(WIN)) u_lut (
      .idx_i (idx),
      .t_o   (t)
    );

    // T < 2^Q_W, so the shifted entry stays below 2^P and the sum fits in P+1 bits.
    assign x_d = WO'(x[P-1:0]) + (WO'(t) << (P - Q_W));

    if (wred_is_reg(g + 1, N, PIPE_EVERY)) begin : g_reg
      localparam int RI = wred_regs_upto(g + 1, N, PIPE_EVERY) - 1;
      logic [WO-1:0] x_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       x_q <= '0;
        else if (en[RI])  x_q <= x_d;
      end
      assign y = x_q;
    end else begin : g_wire
      assign y = x_d;
    end
  end

  // Final stage value is below 3Q, so at most two subtractions are needed.
  localparam logic [CW-1:0] Q1 = CW'(Q);
  localparam logic [CW-1:0] Q2 = CW'(2 * Q);

  logic [CW-1:0]  xf;
  logic [Q_W-1:0] res_d, res_q;

  always_comb begin
    xf = CW'(g_st[N-1].y);
    if (xf >= Q2)      res_d = Q_W'(xf - Q2);
    else if (xf >= Q1) res_d = Q_W'(xf - Q1);
    else               res_d = Q_W'(xf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       res_q <= '0;
    else if (en[NR])  res_q <= res_d;
  end

  assign bus.out_data = res_q;

`ifdef WRED_TAG_EN
  logic [TAG_W-1:0] tag_q [NR+1];
  logic [TAG_W-1:0] tag_d [NR+1];

  always_comb begin
    for (int s = 0; s <= NR; s++) tag_d[s] = tag_q[s];
    if (en[0]) tag_d[0] = bus.in_tag;
    for (int s = 1; s <= NR; s++) if (en[s]) tag_d[s] = tag_q[s-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int s = 0; s <= NR; s++) tag_q[s] <= '0;
    else        for (int s = 0; s <= NR; s++) tag_q[s] <= tag_d[s];
  end

  assign bus.out_tag = tag_q[NR];
`endif
endmodule
